pl_bram_stream_engine: RTL
==========================

// Module: pl_bram_stream_engine
// PURPOSE
//  Parametrised PL compute engine between two PS-shared BRAM ports: on a PS start edge, streams LEN words from source BRAM,
//  applies a selectable ALU op with a PS-supplied operand, writes results to destination BRAM. Pipelined: one word/cycle
//  after fill, vs. one word per 5-cycle trigger. Sits between the PS GPIO/AXI-Lite control regs and two AXI-BRAM ports.
// PARAMETERS
//  DW       32  data width (multiple of 8); byte step STEP = DW/8 (localparam)
//  AW       32  BRAM byte-address width; addresses wrap modulo 2**AW
//  LEN_W    10  width of word-count input (max LEN = 2**LEN_W-1)
//  RD_LAT   1   source BRAM read latency in cycles, legal 1..4
// PORTS
//  clk          in   1      single clock; also driven out on bram clocks
//  rst          in   1      synchronous, active-high reset
//  start        in   1      PS start level; rising edge (registered sample) launches a job
//  mode         in   2      0 pass, 1 add, 2 sub, 3 mul (low DW bits)
//  operand      in   DW     ALU operand
//  src_base     in   AW     source byte address of word 0
//  dst_base     in   AW     destination byte address of word 0
//  len          in   LEN_W  words to process; 0 = no-op job
//  busy         out  1      high from launch until done
//  done_pulse   out  1      one-cycle completion strobe
//  done_toggle  out  1      flips on every completion (PS polling)
//  ovf          out  1      sticky: any add carry / sub borrow / mul truncation in current job
//  start_drop   out  1      one-cycle strobe: start edge seen while busy (ignored)
//  rd_clk, rd_rst, rd_en, rd_we[DW/8], rd_addr[AW], rd_data[DW] (in)   source port; rd_we tied 0, rd_rst = rst
//  wr_clk, wr_rst, wr_en, wr_we[DW/8], wr_addr[AW], wr_data[DW] (out)  destination port; wr_we all-ones when wr_en, wr_rst = rst
// BEHAVIOUR
//  Reset: all registered outputs 0 (busy, done_pulse, done_toggle, ovf, start_drop, rd_en, wr_en, wr_we, addrs, wr_data);
//   state IDLE; in-flight reads/writes discarded; reset mid-job aborts with no done indication.
//  Edge detect: start_q <= start each cycle; launch when start & ~start_q in IDLE. Held-high start launches once only.
//  Launch cycle k: latch mode, operand, src_base, dst_base, len; clear ovf; busy=1 at k+1.
//  FSM: IDLE -> RUN (len>0) or FIN (len==0); RUN -> DRAIN after last read issued; DRAIN -> FIN when pipe empty; FIN -> IDLE.
//  RUN: rd_en=1 each cycle from k+1, rd_addr = src_base + i*STEP for i=0..len-1, contiguous, no bubbles.
//  Valid shift line of RD_LAT stages tracks reads; rd_data captured at the stage matching RD_LAT, then one ALU register
//   stage. Word i written at cycle k+1+i+RD_LAT+1: wr_en=1, wr_addr = dst_base + i*STEP, wr_data = ALU(rd_data_i).
//  ALU, computed in DW+1 (add/sub) or 2*DW (mul) bits, result truncated to DW: add carry, sub borrow (src<operand),
//   mul nonzero upper half -> set ovf (sticky until next launch). pass never sets ovf.
//  FIN (one cycle after last write, or k+1 for len==0): done_pulse=1, done_toggle flips, busy drops next cycle.
//   len==0 issues no rd_en/wr_en.
//  Start edge while busy (RUN/DRAIN/FIN): start_drop=1 for one cycle, job unaffected, no queueing.
//  Address wrap: sums modulo 2**AW, no error. src/dst overlap not checked; PS responsibility.
// STRUCTURE
//  pl_cal_pkg: MODE_PASS/ADD/SUB/MUL localparams, FSM state encodings (IDLE/RUN/DRAIN/FIN), shared by control regs.
//  Sub-module pl_cal_alu: registered ALU (DW param), inputs mode/operand/data/valid, outputs result/valid/ovf.
//  Top keeps FSM, counters, address generation, RD_LAT valid line.
// TESTING
//  T1 DW=32, RD_LAT=1: mem[i]=i, mode add, operand 2, len 4, bases 0/0 -> dst=2,3,4,5 at 0x0..0xC; 4 back-to-back
//     writes; done_pulse 1 cycle after last write; done_toggle 0->1; ovf=0.
//  T2 mode add, src word 0xFFFF_FFFF, operand 1, len 1 -> dst 0x0, ovf=1; next job mode pass clears ovf to 0.
//  T3 len=0 start edge -> zero rd_en/wr_en, done_pulse at k+1, done_toggle flips.
//  T4 RD_LAT=3, mode mul, operand 3, len 8 -> dst[i]=3*src[i]; first wr_en at k+5; throughput 1 word/cycle.
//  T5 second start edge mid-job -> start_drop one cycle, original job completes with correct data, one done only.
//  T6 rst asserted mid RUN -> next cycle wr_en=0, busy=0, done_toggle=0; new start after reset completes normally.

Source files
------------

// File: rtl/pl_bram_stream_engine_pkg.sv
// Shared definitions for the BRAM stream engine: ALU mode codes and FSM states.
package pl_bram_stream_engine_pkg;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_ADD  = 2'd1;
  localparam logic [1:0] MODE_SUB  = 2'd2;
  localparam logic [1:0] MODE_MUL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/pl_bram_stream_engine_if.sv
// BRAM port bundle. The rd_* modports form the source (read-only) port and
// the wr_* modports the destination (write-only) port.
interface pl_bram_stream_engine_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic              clk;
  logic              rst;
  logic              en;
  logic [DW/8-1:0]   we;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     wdata;
  logic [DW-1:0]     rdata;

  modport rd_master (output clk, rst, en, we, addr, input rdata);
  modport rd_slave  (input clk, rst, en, we, addr, output rdata);
  modport wr_master (output clk, rst, en, we, addr, wdata);
  modport wr_slave  (input clk, rst, en, we, addr, wdata);
endinterface

// File: rtl/pl_bram_stream_engine_alu.sv
// Registered ALU stage: one result per valid input word, with a per-word
// overflow flag (add carry, sub borrow, mul truncation).
module pl_bram_stream_engine_alu
  import pl_bram_stream_engine_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic [DW-1:0] operand,
  input  logic [DW-1:0] data,
  input  logic          valid,
  output logic [DW-1:0] result,
  output logic          res_valid,
  output logic          res_ovf
);

  logic [DW:0]     sum;
  logic [DW:0]     diff;
  logic [2*DW-1:0] prod;
  logic [DW-1:0]   nxt;
  logic            nxt_ovf;

  // Widened arithmetic so carry, borrow and upper product half are visible.
  always_comb begin
    sum     = {1'b0, data} + {1'b0, operand};
    diff    = {1'b0, data} - {1'b0, operand};
    prod    = {{DW{1'b0}}, data} * {{DW{1'b0}}, operand};
    nxt     = data;
    nxt_ovf = 1'b0;
    case (mode)
      MODE_PASS: begin
        nxt     = data;
        nxt_ovf = 1'b0;
      end
      MODE_ADD: begin
        nxt     = sum[DW-1:0];
        nxt_ovf = sum[DW];
      end
      MODE_SUB: begin
        nxt     = diff[DW-1:0];
        nxt_ovf = diff[DW];
      end
      MODE_MUL: begin
        nxt     = prod[DW-1:0];
        nxt_ovf = |prod[2*DW-1:DW];
      end
      default: begin
        nxt     = data;
        nxt_ovf = 1'b0;
      end
    endcase
  end

  // Result register; the overflow flag is only meaningful alongside res_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= {DW{1'b0}};
      res_valid <= 1'b0;
      res_ovf   <= 1'b0;
    end else begin
      res_valid <= valid;
      if (valid) begin
        result  <= nxt;
        res_ovf <= nxt_ovf;
      end else begin
        result  <= result;
        res_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pl_bram_stream_engine.sv
// Streams len words from a source BRAM through a registered ALU into a
// destination BRAM, one word per cycle once the read pipeline has filled.
module pl_bram_stream_engine
  import pl_bram_stream_engine_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 32,
  parameter int LEN_W  = 10,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [DW-1:0]       operand,
  input  logic [AW-1:0]       src_base,
  input  logic [AW-1:0]       dst_base,
  input  logic [LEN_W-1:0]    len,
  output logic                busy,
  output logic                done_pulse,
  output logic                done_toggle,
  output logic                ovf,
  output logic                start_drop,
  pl_bram_stream_engine_if.rd_master rd,
  pl_bram_stream_engine_if.wr_master wr
);

  localparam int            STEP   = DW / 8;
  localparam logic [AW-1:0] STEP_A = AW'(STEP);

  state_t              state;
  state_t              next_state;
  logic                start_q;
  logic [1:0]          job_mode;
  logic [DW-1:0]       job_operand;
  logic [AW-1:0]       rd_addr;
  logic [AW-1:0]       wr_addr;
  logic                rd_en;
  logic [LEN_W-1:0]    rd_left;
  logic [RD_LAT-1:0]   vline;
  logic [DW-1:0]       alu_result;
  logic                alu_valid;
  logic                alu_ovf;
  logic                start_edge;
  logic                launch;
  logic                pipe_last;

  assign start_edge = start & ~start_q;
  assign launch     = start_edge & (state == ST_IDLE);
  // Last word is leaving the ALU and nothing is left behind it.
  assign pipe_last  = alu_valid & ~(|vline) & ~rd_en;

  assign rd.clk   = clk;
  assign rd.rst   = rst;
  assign rd.en    = rd_en;
  assign rd.we    = {STEP{1'b0}};
  assign rd.addr  = rd_addr;

  assign wr.clk   = clk;
  assign wr.rst   = rst;
  assign wr.en    = alu_valid;
  assign wr.we    = {STEP{alu_valid}};
  assign wr.addr  = wr_addr;
  assign wr.wdata = alu_result;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: reads are counted down in RUN, DRAIN waits for the pipe.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (launch) begin
          next_state = (len == {LEN_W{1'b0}}) ? ST_FIN : ST_RUN;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (rd_left == LEN_W'(1)) begin
          next_state = ST_DRAIN;
        end else begin
          next_state = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (pipe_last) begin
          next_state = ST_FIN;
        end else begin
          next_state = ST_DRAIN;
        end
      end
      ST_FIN:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Job latching, address generation, read-valid line and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q     <= 1'b0;
      start_drop  <= 1'b0;
      busy        <= 1'b0;
      done_pulse  <= 1'b0;
      done_toggle <= 1'b0;
      ovf         <= 1'b0;
      job_mode    <= MODE_PASS;
      job_operand <= {DW{1'b0}};
      rd_addr     <= {AW{1'b0}};
      wr_addr     <= {AW{1'b0}};
      rd_en       <= 1'b0;
      rd_left     <= {LEN_W{1'b0}};
      vline       <= {RD_LAT{1'b0}};
    end else begin
      start_q    <= start;
      start_drop <= start_edge & (state != ST_IDLE);
      busy       <= (next_state != ST_IDLE);
      done_pulse <= (next_state == ST_FIN);
      if (next_state == ST_FIN) begin
        done_toggle <= ~done_toggle;
      end else begin
        done_toggle <= done_toggle;
      end

      vline[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        vline[i] <= vline[i-1];
      end

      if (launch) begin
        job_mode    <= mode;
        job_operand <= operand;
        ovf         <= 1'b0;
        rd_addr     <= src_base;
        wr_addr     <= dst_base;
        rd_left     <= len;
        rd_en       <= (len != {LEN_W{1'b0}});
      end else begin
        ovf <= ovf | (alu_valid & alu_ovf);
        if (rd_en) begin
          rd_addr <= rd_addr + STEP_A;
          rd_left <= rd_left - LEN_W'(1);
          rd_en   <= (rd_left != LEN_W'(1));
        end else begin
          rd_en   <= 1'b0;
        end
        if (alu_valid) begin
          wr_addr <= wr_addr + STEP_A;
        end else begin
          wr_addr <= wr_addr;
        end
      end
    end
  end

  pl_bram_stream_engine_alu #(.DW(DW)) u_alu (
    .clk       (clk),
    .rst       (rst),
    .mode      (job_mode),
    .operand   (job_operand),
    .data      (rd.rdata),
    .valid     (vline[RD_LAT-1]),
    .result    (alu_result),
    .res_valid (alu_valid),
    .res_ovf   (alu_ovf)
  );

endmodule
